// File: rtl/expr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : expr_arbiter
//  Description : Shares one arithmetic-expression checker between two
//                character requesters. A requester is granted for a whole
//                expression (terminated by ';'), round-robin when both ask.
//                The checker accepts digit ((+|*) digit)* and reports the
//                owner id, well-formedness and saturating length.
//  Ports       : clk            - clock, rising edge
//                clr            - synchronous active-high reset
//                reqN_valid     - requester N presents a character
//                reqN_char[7:0] - requester N ASCII character
//                reqN_ready     - requester N character accepted this cycle
//                res_valid      - one-cycle result strobe
//                res_id         - requester that owned the expression
//                res_ok         - expression well formed
//                res_len[7:0]   - non-terminator character count, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_arbiter (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  output logic       res_valid,
  output logic       res_id,
  output logic       res_ok,
  output logic [7:0] res_len
);

  localparam logic [7:0] C_TERM    = 8'h3B;  // ';'
  localparam logic [7:0] C_PLUS    = 8'h2B;  // '+'
  localparam logic [7:0] C_STAR    = 8'h2A;  // '*'
  localparam logic [7:0] C_ZERO    = 8'h30;  // '0'
  localparam logic [7:0] C_NINE    = 8'h39;  // '9'
  localparam logic [7:0] C_LEN_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_EMPTY = 2'd0,
    K_NUM   = 2'd1,
    K_OP    = 2'd2,
    K_ERR   = 2'd3
  } chk_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       gnt_q, gnt_d;
  chk_t       chk_q, chk_d;
  logic [7:0] len_q, len_d;
  logic       res_id_q, res_id_d;
  logic       res_ok_q, res_ok_d;
  logic [7:0] res_len_q, res_len_d;

  logic       w_sel_valid;
  logic [7:0] w_sel_char;
  logic       w_busy_ready;
  logic       w_xfer;
  logic       w_gnt_new;

  function automatic chk_t chk_next(input chk_t cur, input logic [7:0] ch);
    logic is_digit;
    logic is_op;
    chk_t nxt;
    is_digit = (ch >= C_ZERO) && (ch <= C_NINE);
    is_op    = (ch == C_PLUS) || (ch == C_STAR);
    nxt      = K_ERR;
    case (cur)
      K_EMPTY: nxt = is_digit ? K_NUM : K_ERR;
      K_NUM:   nxt = is_op    ? K_OP  : K_ERR;
      K_OP:    nxt = is_digit ? K_NUM : K_ERR;
      default: nxt = K_ERR;
    endcase
    return nxt;
  endfunction

  // Only the granted requester is looked at; the other is left untouched.
  assign w_sel_valid  = gnt_q ? req1_valid : req0_valid;
  assign w_sel_char   = gnt_q ? req1_char  : req0_char;
  // Ready is suppressed during clr so nothing transfers on a reset edge.
  assign w_busy_ready = (state_q == S_BUSY) && !clr;
  assign w_xfer       = w_busy_ready && w_sel_valid;
  // Contention goes to prio; a lone requester simply wins.
  assign w_gnt_new    = (req0_valid && req1_valid) ? prio_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    chk_d      = chk_q;
    len_d      = len_q;
    res_id_d   = res_id_q;
    res_ok_d   = res_ok_q;
    res_len_d  = res_len_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = w_gnt_new;
          // The loser of this round (or the idle one) is favoured next time.
          prio_d  = ~w_gnt_new;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        req0_ready = w_busy_ready && !gnt_q;
        req1_ready = w_busy_ready &&  gnt_q;
        if (w_xfer) begin
          if (w_sel_char == C_TERM) begin
            res_id_d  = gnt_q;
            res_ok_d  = (chk_q == K_NUM);
            res_len_d = len_q;
            state_d   = S_REPORT;
          end else begin
            chk_d = chk_next(chk_q, w_sel_char);
            if (len_q != C_LEN_MAX) begin
              len_d = len_q + 8'd1;
            end
          end
        end
      end

      S_REPORT: begin
        res_valid = 1'b1;
        chk_d     = K_EMPTY;
        len_d     = 8'd0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      chk_q     <= K_EMPTY;
      len_q     <= 8'd0;
      res_id_q  <= 1'b0;
      res_ok_q  <= 1'b0;
      res_len_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      chk_q     <= chk_d;
      len_q     <= len_d;
      res_id_q  <= res_id_d;
      res_ok_q  <= res_ok_d;
      res_len_q <= res_len_d;
    end
  end

  assign res_id  = res_id_q;
  assign res_ok  = res_ok_q;
  assign res_len = res_len_q;

endmodule
`default_nettype wire
